// File: rtl/bit_serial_adder_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder controller.
// Imported by the controller and its bench.
package bit_serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serial_adder_ctrl_f_adder.sv
// Single-bit full-adder cell used by the serial datapath.
// Port names match the existing library cell.
module f_adder (
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, one result bit per clock.
// Results and flags are registered and held until the next completion.
module bit_serial_adder_ctrl
  import bit_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic             carry_q;
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] sum_next;
  logic             accept;
  logic             last;
  logic             s_bit;
  logic             c_bit;

  f_adder u_cell (
    .S    (s_bit),
    .Cout (c_bit),
    .A    (sa_q[0]),
    .B    (sb_q[0]),
    .Cin  (carry_q)
  );

  // Bits computed so far sit below the fresh sum bit.
  assign sum_next = {s_bit, res_q};

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      carry_q  <= 1'b0;
      res_q    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      sa_q    <= a;
      sb_q    <= b;
      carry_q <= cin;
      res_q   <= '0;
    end else if (state_q == RUN) begin
      sa_q    <= sa_q >> 1;
      sb_q    <= sb_q >> 1;
      carry_q <= c_bit;
      res_q   <= sum_next[WIDTH-1:1];
      if (last) begin
        sum      <= sum_next;
        cout     <= c_bit;
        // carry_q is the carry entering the MSB cell
        overflow <= carry_q ^ c_bit;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
